airlock_interlock: RTL and testbench
====================================

# airlock_interlock

Airlock interlock controller for the lab board: consumes the slide switches and active-low push keys, and sequences two doors and a chamber pressure pump.
- Enforces the interlock: the outer door opens only at pressure 0, the inner door only at full pressure, and never both doors at once.
- It is the design-under-test that the InterlockSystem bench stimulus drives; its outputs go to board LEDs.

## Interface
Parameters:
- PRESS_MAX, 8: full-pressure level, ≥1.
- PUMP_TICKS, 4: clock cycles per pressure step, ≥1.

Ports:
- Clock, input, 1: single clock; all state on posedge.
- Reset, input, 1: asynchronous, active-high.
- Key0, input, 1: arrival request, active-low push key.
- Key1, input, 1: pressurize request, active-low push key.
- Key2, input, 1: depressurize request, active-low push key.
- SW0, input, 1: pump hold; 1 pauses pumping (see Configuration).
- SW2, input, 1: outer-door open request (level, 1 = open).
- SW3, input, 1: inner-door open request (level, 1 = open).
- OuterDoor, output, 1: outer door open.
- InnerDoor, output, 1: inner door open.
- Pressure, output, $clog2(PRESS_MAX+1): chamber pressure.
- Pumping, output, 1: PRESSURIZING or DEPRESSURIZING.
- ArriveLED, output, 1: arrival pending.
- FaultLED, output, 1: last request rejected.

## Operation
Input conditioning:
- Every key and switch passes through a 2-flop synchronizer.
- A key "press" is a 1→0 transition of the synchronized key: a one-cycle pulse.
- Switches are used as synchronized levels.

States: IDLE_LOW (reset state), OUTER_OPEN, PRESSURIZING, IDLE_HIGH, INNER_OPEN, DEPRESSURIZING.

Transitions:
- IDLE_LOW:
  - SW2=1 → OUTER_OPEN. Takes priority over everything else.
  - Key1 press with SW2=SW3=0 → PRESSURIZING.
- OUTER_OPEN: SW2=0 → IDLE_LOW.
- PRESSURIZING:
  - Pressure reaches PRESS_MAX → IDLE_HIGH.
  - Key2 press → DEPRESSURIZING.
- IDLE_HIGH:
  - SW3=1 → INNER_OPEN.
  - Key2 press with SW3=0 → DEPRESSURIZING.
- INNER_OPEN: SW3=0 → IDLE_HIGH.
- DEPRESSURIZING:
  - Pressure reaches 0 → IDLE_LOW.
  - Key1 press → PRESSURIZING.

Rejected requests (set FaultLED, no state change):
- SW3=1 in IDLE_LOW.
- SW2=1 in IDLE_HIGH.
- Any Key1/Key2 press while a door is open.
- Key1 in IDLE_HIGH; Key2 in IDLE_LOW.
- Key1 and Key2 pressed in the same cycle: both ignored, FaultLED set.
- Door switches during pumping: ignored silently.

FaultLED:
- Sticky.
- Cleared by the next accepted transition.

ArriveLED:
- Set by a Key0 press in any state.
- Cleared on entry to OUTER_OPEN.
- Set and clear in the same cycle: clear wins.

Pump arithmetic:
- An internal tick counter is cleared on every entry to a pumping state.
- The tick counter increments each pumping cycle (not held).
- At tick = PUMP_TICKS-1: tick clears and Pressure steps ±1.
- Pressure saturates at 0 and PRESS_MAX and never wraps.

Outputs:
- Door and Pumping outputs are decoded from the state register.

## Timing
- Reset (async) values:
  - State = IDLE_LOW.
  - Pressure = 0, tick = 0.
  - All outputs 0.
  - Key synchronizers = 1, switch synchronizers = 0.
  - Mid-pump reset drops Pressure to 0 immediately.
- Input latency:
  - An input level first sampled at posedge k is acted on at posedge k+2.
  - The state and output change is visible after posedge k+2.
- Pump timing:
  - With entry to PRESSURIZING at edge E, Pressure increments at E+n·PUMP_TICKS.
  - At E+PRESS_MAX·PUMP_TICKS: Pressure=PRESS_MAX and state=IDLE_HIGH at the same edge.
- Reversal mid-pump: Pressure holds its value, tick restarts, and the next step comes PUMP_TICKS cycles after the reversal edge.
- A key held low produces exactly one press; a new press requires release.

## Configuration
- PUMP_HOLD_EN defined:
  - SW0=1 freezes the tick counter and Pressure while in a pumping state.
  - Transitions on Key1/Key2 are still accepted.
- PUMP_HOLD_EN undefined: SW0 is ignored and its synchronizer is omitted.

## Test plan
Bench uses PRESS_MAX=4, PUMP_TICKS=2.
- Reset then idle 3 cycles → State IDLE_LOW; Pressure=0; OuterDoor=InnerDoor=Pumping=ArriveLED=FaultLED=0.
- Key0 low 2 cycles, then SW2=1 → ArriveLED=1 two edges after the press; OuterDoor=1 and ArriveLED=0 two edges after SW2 rises; SW2=0 → OuterDoor=0.
- Key1 press in IDLE_LOW → Pumping=1; Pressure 1,2,3,4 every 2 cycles; at 4, Pumping=0 and state IDLE_HIGH; then SW3=1 → InnerDoor=1.
- SW2=1 in IDLE_HIGH → FaultLED=1 and OuterDoor=0; then Key2 press → FaultLED=0, Pressure counts down to 0, then IDLE_LOW.
- Key1 press, then Key2 press when Pressure=2 → Pressure holds at 2 for one step period, then 1, 0; Key1 and Key2 pressed together → FaultLED=1, no state change.
- With PUMP_HOLD_EN: SW0=1 mid-pressurize → Pressure frozen while SW0=1 and resumes after release. Without the macro: SW0=1 has no effect.

Source files
------------

// File: rtl/airlock_interlock.sv
// airlock_interlock: two-door airlock sequencer with chamber pressure pump and door interlock.
// Define PUMP_HOLD_EN to let SW0 pause pumping; otherwise SW0 is ignored.
module airlock_interlock #(
  parameter int PRESS_MAX  = 8,
  parameter int PUMP_TICKS = 4,
  localparam int PW = $clog2(PRESS_MAX + 1),
  localparam int TW = (PUMP_TICKS > 1) ? $clog2(PUMP_TICKS) : 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          Key0,
  input  logic          Key1,
  input  logic          Key2,
  input  logic          SW0,
  input  logic          SW2,
  input  logic          SW3,
  output logic          OuterDoor,
  output logic          InnerDoor,
  output logic [PW-1:0] Pressure,
  output logic          Pumping,
  output logic          ArriveLED,
  output logic          FaultLED
);
  typedef enum logic [2:0] {
    IDLE_LOW, OUTER_OPEN, PRESSURIZING, IDLE_HIGH, INNER_OPEN, DEPRESSURIZING
  } state_t;
  state_t r_state, w_next;
  logic [2:0] r_key_s1, r_key_s2, r_key_d, w_press;
  logic [1:0] r_sw_s1, r_sw_s2;
  logic [PW-1:0] r_press;
  logic [TW-1:0] r_tick;
  logic r_fault, r_arrive;
  logic w_hold, w_pump, w_step, w_up, w_dn, w_fault, w_k0, w_k1, w_k2, w_sw2, w_sw3;
  // keys idle high, so their synchronizers reset to 1 to avoid a spurious press
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      r_key_s1 <= '1;
      r_key_s2 <= '1;
      r_key_d  <= '1;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= {Key2, Key1, Key0};
      r_key_s2 <= r_key_s1;
      r_key_d  <= r_key_s2;
      r_sw_s1  <= {SW3, SW2};
      r_sw_s2  <= r_sw_s1;
    end
  assign w_press = r_key_d & ~r_key_s2;
  assign w_k0 = w_press[0];
  assign w_k1 = w_press[1];
  assign w_k2 = w_press[2];
  assign w_sw2 = r_sw_s2[0];
  assign w_sw3 = r_sw_s2[1];
`ifdef PUMP_HOLD_EN
  logic [1:0] r_hold_s;
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) r_hold_s <= '0;
    else r_hold_s <= {r_hold_s[0], SW0};
  assign w_hold = r_hold_s[1];
`else
  logic w_unused;
  assign w_unused = SW0;
  assign w_hold = 1'b0;
`endif
  assign w_pump = (r_state == PRESSURIZING) || (r_state == DEPRESSURIZING);
  assign w_step = w_pump && !w_hold && (r_tick == TW'(PUMP_TICKS - 1));
  always_comb begin
    w_next = r_state;
    w_fault = 1'b0;
    w_up = 1'b0;
    w_dn = 1'b0;
    case (r_state)
      IDLE_LOW:
        if (w_sw2) w_next = OUTER_OPEN;
        else if (w_k1 && !w_k2 && !w_sw3) w_next = PRESSURIZING;
        else w_fault = w_sw3 | w_k1 | w_k2;
      OUTER_OPEN:
        if (!w_sw2) w_next = IDLE_LOW;
        else w_fault = w_k1 | w_k2;
      IDLE_HIGH:
        if (w_sw3) w_next = INNER_OPEN;
        else if (w_k2 && !w_k1) w_next = DEPRESSURIZING;
        else w_fault = w_sw2 | w_k1 | w_k2;
      INNER_OPEN:
        if (!w_sw3) w_next = IDLE_HIGH;
        else w_fault = w_k1 | w_k2;
      PRESSURIZING: begin
        w_fault = w_k1 & w_k2;
        if (w_k2 && !w_k1) w_next = DEPRESSURIZING;
        else begin
          w_up = w_step;
          if (w_step && r_press >= PW'(PRESS_MAX - 1)) w_next = IDLE_HIGH;
        end
      end
      DEPRESSURIZING: begin
        w_fault = w_k1 & w_k2;
        if (w_k1 && !w_k2) w_next = PRESSURIZING;
        else begin
          w_dn = w_step;
          if (w_step && r_press <= PW'(1)) w_next = IDLE_LOW;
        end
      end
      default: w_next = IDLE_LOW;
    endcase
  end
  // any state change restarts the pump period and counts as an accepted request
  always_ff @(posedge Clock or posedge Reset)
    if (Reset) begin
      r_state  <= IDLE_LOW;
      r_press  <= '0;
      r_tick   <= '0;
      r_fault  <= 1'b0;
      r_arrive <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_tick   <= (w_next != r_state || w_step) ? '0 : r_tick + TW'(w_pump & ~w_hold);
      r_press  <= (w_up && r_press != PW'(PRESS_MAX)) ? r_press + 1'b1 :
                  (w_dn && r_press != '0) ? r_press - 1'b1 : r_press;
      r_fault  <= (w_next != r_state) ? 1'b0 : r_fault | w_fault;
      r_arrive <= (w_next == OUTER_OPEN && r_state != OUTER_OPEN) ? 1'b0 : r_arrive | w_k0;
    end
  assign OuterDoor = r_state == OUTER_OPEN;
  assign InnerDoor = r_state == INNER_OPEN;
  assign Pumping = w_pump;
  assign Pressure = r_press;
  assign ArriveLED = r_arrive;
  assign FaultLED = r_fault;
endmodule

// File: tb/tb_airlock_interlock.sv
// tb_airlock_interlock: directed and randomized checks of airlock_interlock against a rule-level model.
module tb_airlock_interlock;
  localparam int PM = 4;
  localparam int PT = 2;
  localparam int IL = 0, OO = 1, PR = 2, IH = 3, IO = 4, DP = 5;
`ifdef PUMP_HOLD_EN
  localparam int HOLD_P = 2;
`else
  localparam int HOLD_P = 4;
`endif
  logic clk = 0, rst = 1, sw0 = 0, sw2 = 0, sw3 = 0;
  logic [2:0] keys = 3'b111;
  logic od, id, pumping, arr, flt;
  logic [2:0] pr;
  wire [7:0] obs = {od, id, pumping, arr, flt, pr};
  int n_chk = 0, n_fail = 0;
  int m_st, m_p, m_run;
  bit m_arr, m_flt;
  logic [5:0] h[4];

  airlock_interlock #(.PRESS_MAX(PM), .PUMP_TICKS(PT)) dut (
    .Clock(clk), .Reset(rst), .Key0(keys[0]), .Key1(keys[1]), .Key2(keys[2]),
    .SW0(sw0), .SW2(sw2), .SW3(sw3), .OuterDoor(od), .InnerDoor(id),
    .Pressure(pr), .Pumping(pumping), .ArriveLED(arr), .FaultLED(flt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mexp();
    return {m_st == OO, m_st == IO, m_st == PR || m_st == DP, m_arr, m_flt, 3'(m_p)};
  endfunction

  task automatic model_reset();
    m_st = IL; m_p = 0; m_run = 0; m_arr = 0; m_flt = 0;
    for (int i = 0; i < 4; i++) h[i] = 6'b000111;
  endtask

  // inputs seen at edge E-2 are acted on at E; a press is a 1 at E-3 followed by 0 at E-2
  task automatic model_edge();
    logic [5:0] a, b;
    bit p0, p1, p2, s2, s3, hold, step, fs;
    int ns;
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = {sw0, sw3, sw2, keys};
    a = h[2]; b = h[3];
    p0 = b[0] & ~a[0]; p1 = b[1] & ~a[1]; p2 = b[2] & ~a[2];
    s2 = a[3]; s3 = a[4];
`ifdef PUMP_HOLD_EN
    hold = a[5];
`else
    hold = 0;
`endif
    ns = m_st; fs = 0; step = 0;
    if ((m_st == PR || m_st == DP) && !hold) begin
      m_run++;
      step = (m_run % PT) == 0;
    end
    case (m_st)
      IL: if (s2) ns = OO; else if (p1 && !p2 && !s3) ns = PR; else fs = s3 | p1 | p2;
      OO: if (!s2) ns = IL; else fs = p1 | p2;
      IH: if (s3) ns = IO; else if (p2 && !p1) ns = DP; else fs = s2 | p1 | p2;
      IO: if (!s3) ns = IH; else fs = p1 | p2;
      PR: begin
        fs = p1 & p2;
        if (p2 && !p1) ns = DP;
        else if (step) begin
          m_p = (m_p < PM) ? m_p + 1 : PM;
          if (m_p == PM) ns = IH;
        end
      end
      default: begin
        fs = p1 & p2;
        if (p1 && !p2) ns = PR;
        else if (step) begin
          m_p = (m_p > 0) ? m_p - 1 : 0;
          if (m_p == 0) ns = IL;
        end
      end
    endcase
    if (ns != m_st) begin m_run = 0; m_flt = 0; end
    else m_flt = m_flt | fs;
    m_arr = (ns == OO && m_st != OO) ? 1'b0 : (m_arr | p0);
    m_st = ns;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset(); else model_edge();
      #1;
    end
  endtask

  task automatic press_key(input logic [2:0] m);
    keys = keys & ~m;
    cyc(2);
    keys = keys | m;
    cyc(1);
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(2);
    rst = 0;
    cyc(3);
    n_chk++; if (obs !== 8'd0) begin n_fail++; $display("FAIL reset_outputs: got %b want %b", obs, 8'd0); end
    n_chk++; if (obs !== mexp()) begin n_fail++; $display("FAIL reset_model: got %b want %b", obs, mexp()); end
  endtask

  task automatic test_arrive();
    press_key(3'b001);
    n_chk++; if (arr !== 1'b1 || obs !== mexp()) begin n_fail++; $display("FAIL arrive_set: got %b want %b", obs, mexp()); end
    sw2 = 1;
    cyc(2);
    n_chk++; if (od !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL outer_latency: got %b want %b", obs, mexp()); end
    cyc(1);
    n_chk++; if (od !== 1'b1 || arr !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL outer_open: got %b want %b", obs, mexp()); end
    sw2 = 0;
    cyc(3);
    n_chk++; if (od !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL outer_close: got %b want %b", obs, mexp()); end
  endtask

  task automatic test_pressurize();
    press_key(3'b010);
    n_chk++; if (pumping !== 1'b1 || pr !== 3'd0 || obs !== mexp()) begin n_fail++; $display("FAIL press_start: got %b want %b", obs, mexp()); end
    for (int n = 1; n <= PM; n++) begin
      cyc(PT);
      n_chk++;
      if (pr !== 3'(n) || pumping !== (n < PM) || obs !== mexp()) begin
        n_fail++; $display("FAIL press_step%0d: got %b want %b", n, obs, mexp());
      end
    end
    sw3 = 1;
    cyc(3);
    n_chk++; if (id !== 1'b1 || od !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL inner_open: got %b want %b", obs, mexp()); end
    sw3 = 0;
    cyc(3);
    n_chk++; if (id !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL inner_close: got %b want %b", obs, mexp()); end
  endtask

  task automatic test_fault();
    sw2 = 1;
    cyc(3);
    n_chk++; if (flt !== 1'b1 || od !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL outer_at_high: got %b want %b", obs, mexp()); end
    sw2 = 0;
    press_key(3'b100);
    n_chk++; if (flt !== 1'b0 || pumping !== 1'b1 || obs !== mexp()) begin n_fail++; $display("FAIL fault_clear: got %b want %b", obs, mexp()); end
    cyc(PM * PT);
    n_chk++; if (pr !== 3'd0 || pumping !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL depress_done: got %b want %b", obs, mexp()); end
  endtask

  task automatic test_reversal();
    press_key(3'b010);
    cyc(2);
    keys[2] = 0;
    cyc(2);
    keys[2] = 1;
    cyc(1);
    n_chk++; if (pr !== 3'd2 || pumping !== 1'b1 || obs !== mexp()) begin n_fail++; $display("FAIL rev_edge: got %b want %b", obs, mexp()); end
    cyc(1);
    n_chk++; if (pr !== 3'd2 || obs !== mexp()) begin n_fail++; $display("FAIL rev_hold: got %b want %b", obs, mexp()); end
    cyc(1);
    n_chk++; if (pr !== 3'd1 || obs !== mexp()) begin n_fail++; $display("FAIL rev_step: got %b want %b", obs, mexp()); end
    cyc(2);
    n_chk++; if (pr !== 3'd0 || pumping !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL rev_low: got %b want %b", obs, mexp()); end
    press_key(3'b110);
    n_chk++; if (flt !== 1'b1 || pumping !== 1'b0 || od !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL both_keys: got %b want %b", obs, mexp()); end
  endtask

  task automatic test_hold();
    press_key(3'b010);
    cyc(2);
    sw0 = 1;
    cyc(6);
    n_chk++; if (pr !== 3'(HOLD_P) || obs !== mexp()) begin n_fail++; $display("FAIL hold_freeze: got %b want %b", obs, mexp()); end
    sw0 = 0;
    cyc(8);
    n_chk++; if (pr !== 3'd4 || pumping !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL hold_resume: got %b want %b", obs, mexp()); end
    press_key(3'b100);
    cyc(PM * PT);
    n_chk++; if (pr !== 3'd0 || pumping !== 1'b0 || obs !== mexp()) begin n_fail++; $display("FAIL hold_back_low: got %b want %b", obs, mexp()); end
  endtask

  task automatic test_mid_reset();
    press_key(3'b010);
    cyc(3);
    #2 rst = 1;
    #1;
    n_chk++; if (obs !== 8'd0) begin n_fail++; $display("FAIL async_reset: got %b want %b", obs, 8'd0); end
    cyc(1);
    rst = 0;
    cyc(2);
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      keys = {$urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(3) != 0};
      sw2 = $urandom_range(5) == 0;
      sw3 = $urandom_range(5) == 0;
      sw0 = $urandom_range(3) == 0;
      repeat ($urandom_range(1, 5)) begin
        cyc(1);
        n_chk++;
        if (obs !== mexp()) begin n_fail++; $display("FAIL random_it%0d: got %b want %b", it, obs, mexp()); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_arrive();
    test_pressurize();
    test_fault();
    test_reversal();
    test_hold();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
